// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter with valid/ready load and bit strobe
// Each accepted word leaves as exactly WIDTH contiguous valid bits; a word can be reloaded on its last bit.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sout_n;
  logic             accept;

  assign serial_valid = (state == SHIFT);
  assign busy         = serial_valid;
  assign last         = serial_valid && (cnt == '0);
  // Ready depends only on registered state, so load_valid never loops back into it.
  assign load_ready   = (state == IDLE) || last;
  assign accept       = load_valid && load_ready;

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    sout_n  = serial_out;
    if (accept) begin
      state_n = SHIFT;
      cnt_n   = CW'(WIDTH - 1);
      if (LSB_FIRST) begin
        sout_n  = parallel_in[0];
        shreg_n = parallel_in >> 1;
      end else begin
        sout_n  = parallel_in[WIDTH-1];
        shreg_n = parallel_in << 1;
      end
    end else if (state == SHIFT) begin
      if (cnt == '0) begin
        state_n = IDLE;
        sout_n  = 1'b0;
      end else begin
        cnt_n = cnt - CW'(1);
        if (LSB_FIRST) begin
          sout_n  = shreg[0];
          shreg_n = shreg >> 1;
        end else begin
          sout_n  = shreg[WIDTH-1];
          shreg_n = shreg << 1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      serial_out <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      serial_out <= sout_n;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer at three widths
// A bit-queue reference model predicts every output each cycle; directed scenarios check bit sequences.
module tb_piso_serializer;

  localparam int W_OF [3] = '{4, 8, 1};
  localparam bit L_OF [3] = '{1'b1, 1'b0, 1'b1};

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       lv [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] pi [3] = '{8'h0, 8'h0, 8'h0};
  logic       so [3], sv [3], la [3], bz [3], lr [3];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic m_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic m_bit   [3] = '{1'b0, 1'b0, 1'b0};
  logic m_last  [3] = '{1'b0, 1'b0, 1'b0};
  logic m_acc   [3] = '{1'b0, 1'b0, 1'b0};
  bit   m_pend  [3][$];
  bit   obs_b   [3][$];
  bit   obs_l   [3][$];
  logic [3:0] sipo = 4'h0;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_w4 (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(lr[0]),
    .parallel_in(pi[0][3:0]), .serial_out(so[0]), .serial_valid(sv[0]),
    .last(la[0]), .busy(bz[0]));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_w8 (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(lr[1]),
    .parallel_in(pi[1]), .serial_out(so[1]), .serial_valid(sv[1]),
    .last(la[1]), .busy(bz[1]));

  piso_serializer #(.WIDTH(1), .LSB_FIRST(1'b1)) u_w1 (
    .clk(clk), .reset(reset), .load_valid(lv[2]), .load_ready(lr[2]),
    .parallel_in(pi[2][0:0]), .serial_out(so[2]), .serial_valid(sv[2]),
    .last(la[2]), .busy(bz[2]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a word becomes a queue of bits in transmit order; one bit pops per clock.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 1'b0;
      if (reset) begin
        m_pend[i].delete();
        m_valid[i] = 1'b0; m_bit[i] = 1'b0; m_last[i] = 1'b0;
      end else begin
        if (lv[i] && (!m_valid[i] || m_last[i])) begin
          m_acc[i] = 1'b1;
          m_pend[i].delete();
          for (int b = 0; b < W_OF[i]; b++)
            m_pend[i].push_back(L_OF[i] ? pi[i][b] : pi[i][W_OF[i]-1-b]);
        end
        if (m_pend[i].size() > 0) begin
          m_bit[i]   = m_pend[i].pop_front();
          m_valid[i] = 1'b1;
          m_last[i]  = (m_pend[i].size() == 0);
        end else begin
          m_valid[i] = 1'b0; m_bit[i] = 1'b0; m_last[i] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) if (sv[0] === 1'b1) sipo <= {so[0], sipo[3:1]};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sv[i] === 1'b1) begin
        obs_b[i].push_back(so[i]);
        obs_l[i].push_back(la[i]);
      end
      if (chk_en)
        check("outs{so,sv,last,busy,ready}",
              32'({so[i], sv[i], la[i], bz[i], lr[i]}),
              32'({m_bit[i], m_valid[i], m_last[i], m_valid[i], !m_valid[i] || m_last[i]}));
    end
  end

  task automatic send(input int i, input logic [7:0] d);
    bit done = 1'b0;
    lv[i] = 1'b1;
    pi[i] = d;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      if (m_acc[i]) done = 1'b1;
    end
    if (!done) check("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int i, input int n);
    lv[i] = 1'b0;
    pi[i] = 8'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs(input int i);
    obs_b[i].delete();
    obs_l[i].delete();
  endtask

  task automatic scen_check(input int i, input string tag, input int n,
                            input logic [31:0] exp_b, input logic [31:0] exp_l);
    logic [31:0] vb = 0, vl = 0;
    for (int k = 0; k < obs_b[i].size(); k++) begin
      vb = (vb << 1) | 32'(obs_b[i][k]);
      vl = (vl << 1) | 32'(obs_l[i][k]);
    end
    check({tag, "_count"}, 32'(obs_b[i].size()), 32'(n));
    check({tag, "_bits"}, vb, exp_b);
    check({tag, "_last"}, vl, exp_l);
    clear_obs(i);
  endtask

  task automatic run_rand(input int i);
    for (int w = 0; w < 25; w++) begin
      send(i, 8'($urandom));
      if ($urandom_range(0, 2) == 0) idle(i, $urandom_range(1, 5));
    end
    idle(i, W_OF[i] + 3);
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("reset_state", 32'({so[0], sv[0], la[0], bz[0], lr[0]}), 32'b00001);
    idle(0, 10);

    clear_obs(0);
    send(0, 8'h0B);
    idle(0, 6);
    scen_check(0, "w4_1011", 4, 32'b1101, 32'b0001);
    check("sipo_word", 32'(sipo), 32'hB);

    send(0, 8'h0A);
    send(0, 8'h05);
    idle(0, 6);
    scen_check(0, "b2b_a5", 8, 32'h5A, 32'h11);

    send(0, 8'h00);
    lv[0] = 1'b0;
    @(posedge clk); #1;
    lv[0] = 1'b1; pi[0] = 8'h0F;
    @(posedge clk); #1;
    idle(0, 8);
    scen_check(0, "busy_reject", 4, 32'b0000, 32'b0001);

    send(0, 8'h0E);
    lv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_reset", 32'({so[0], sv[0], la[0], bz[0], lr[0]}), 32'b00001);
    @(posedge clk); #2;
    reset = 1'b0;
    clear_obs(0);
    idle(0, 2);
    send(0, 8'h03);
    idle(0, 6);
    scen_check(0, "after_reset", 4, 32'b1100, 32'b0001);

    clear_obs(1);
    send(1, 8'h81);
    idle(1, 10);
    scen_check(1, "w8_msb", 8, 32'h81, 32'h01);

    clear_obs(2);
    send(2, 8'h01);
    send(2, 8'h00);
    send(2, 8'h01);
    idle(2, 4);
    scen_check(2, "w1_stream", 3, 32'b101, 32'b111);

    fork
      run_rand(0);
      run_rand(1);
      run_rand(2);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
